// File: rtl/line_mem_responder.sv
// line_mem_responder: 256-bit line memory endpoint with fixed response latency
// and sticky initiator protocol checking.
module line_mem_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic         mem_resp,
  output logic [255:0] mem_rdata,
  output logic [3:0]   errcode,
  output logic         pm_error
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d, rdata_q;
  logic [3:0]     err_q, err_d;
  logic           pm_q;
  logic           req, both, accept, differs;
  logic [255:0]   store_q [DEPTH] = '{default: '0};
  always_comb begin
    req     = mem_read | mem_write;
    both    = mem_read & mem_write;
    accept  = (state_q == IDLE) && req && !both;
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      wr_d    = mem_write;
      addr_d  = mem_address;
      wdata_d = mem_wdata;
      cnt_d   = 8'(LATENCY - 1);
      state_d = (LATENCY == 1) ? RESP : BUSY;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 8'd1;
      state_d = (cnt_q == 8'd1) ? RESP : BUSY;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    differs = (mem_write != wr_q) || (mem_read == wr_q) || (mem_address != addr_q) ||
              (wr_q && (mem_wdata != wdata_q));
    err_d   = err_q | {(state_q == BUSY) && !req,
                       (state_q != IDLE) && req && differs,
                       accept && (|mem_address[4:0]),
                       both};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pm_q    <= |err_d;
      if (state_d == RESP && !wr_d) rdata_q <= store_q[addr_d[5 +: IW]];
    end
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end
  // The store survives rst; only the aborted transaction's commit is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q) store_q[addr_q[5 +: IW]] <= wdata_q;
  end
  assign mem_resp  = (state_q == RESP) && !rst;
  assign mem_rdata = rdata_q;
  assign errcode   = err_q;
  assign pm_error  = pm_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed checks of latency, data, aliasing, reset abort
// and protocol error flags.
module tb_line_mem_responder;
  logic         clk = 1'b0, rst = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic         mem_resp, pm_error;
  logic [255:0] mem_rdata, rd;
  logic [3:0]   errcode;
  int           n_cmp = 0, n_err = 0, n, hits;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] X  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] Y  = {8{32'h5A5A_F00D}};

  line_mem_responder dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .errcode(errcode), .pm_error(pm_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 1: switch address to alt at cycle k; mode 2: drop the request at cycle k
  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [255:0] d,
                     input int k, input int mode, input logic [31:0] alt,
                     output int cyc, output logic [255:0] data);
    mem_read = r; mem_write = w; mem_address = a; mem_wdata = d; cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (cyc == k && mode == 1) mem_address = alt;
      if (cyc == k && mode == 2) begin mem_read = 1'b0; mem_write = 1'b0; end
    end while (!mem_resp && cyc < 40);
    data = mem_rdata;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_resp", 256'(mem_resp), 256'(0));
      chk("idle_rdata", mem_rdata, 256'(0));
      chk("idle_err", 256'(errcode), 256'(0));
    end
    txn(1'b0, 1'b1, 32'h40, A5, 0, 0, 32'h0, n, rd);
    chk("wr_latency", 256'(n), 256'(10));
    txn(1'b1, 1'b0, 32'h40, '0, 0, 0, 32'h0, n, rd);
    chk("rd_latency_b2b", 256'(n), 256'(10));
    chk("rd_data_a5", rd, A5);
    txn(1'b0, 1'b1, 32'h0, X, 0, 0, 32'h0, n, rd);
    chk("rdata_hold_on_write", rd, A5);
    txn(1'b1, 1'b0, 32'h800, '0, 0, 0, 32'h0, n, rd);
    chk("alias_data", rd, X);
    chk("alias_err", 256'(errcode), 256'(0));
    chk("alias_pm", 256'(pm_error), 256'(0));
    mem_write = 1'b1; mem_address = 32'h100; mem_wdata = Y; hits = 0;
    repeat (5) begin @(posedge clk); #1; hits += int'(mem_resp); end
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; hits += int'(mem_resp); end
    chk("rst_abort_resp", 256'(hits), 256'(0));
    txn(1'b1, 1'b0, 32'h100, '0, 0, 0, 32'h0, n, rd);
    chk("rst_abort_latency", 256'(n), 256'(10));
    chk("rst_abort_data", rd, 256'(0));
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h20;
    chk("both_err_pre", 256'(errcode), 256'(0));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    chk("both_err", 256'(errcode), 256'(4'b0001));
    chk("both_pm", 256'(pm_error), 256'(1));
    hits = 0;
    repeat (15) begin @(posedge clk); #1; hits += int'(mem_resp); end
    chk("both_no_resp", 256'(hits), 256'(0));
    chk("both_sticky", 256'(errcode), 256'(4'b0001));
    txn(1'b1, 1'b0, 32'h44, '0, 0, 0, 32'h0, n, rd);
    chk("misalign_latency", 256'(n), 256'(10));
    chk("misalign_data", rd, A5);
    chk("misalign_err", 256'(errcode), 256'(4'b0011));
    txn(1'b1, 1'b0, 32'h40, '0, 4, 1, 32'h60, n, rd);
    chk("addr_change_data", rd, A5);
    chk("addr_change_err", 256'(errcode), 256'(4'b0111));
    txn(1'b1, 1'b0, 32'h40, '0, 3, 2, 32'h0, n, rd);
    chk("drop_latency", 256'(n), 256'(10));
    chk("drop_data", rd, A5);
    chk("drop_err", 256'(errcode), 256'(4'b1111));
    chk("drop_pm", 256'(pm_error), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("final_rst_err", 256'(errcode), 256'(0));
    chk("final_rst_pm", 256'(pm_error), 256'(0));
    chk("final_rst_rdata", mem_rdata, 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
